// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: the generator drives coordinates, syncs and strobes;
// the consumer side owns the enable that freezes the raster.
interface vga_timing_gen_if #(
    parameter int FCNT_W = 16
);
    logic              enable;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              hs;
    logic              vs;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_count;

    modport master (
        input  enable,
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        output enable,
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Every output is a register decoded from the
// next-count value, so syncs, blank and strobes line up with DrawX/DrawY.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FCNT_W    = 16
) (
    input  logic                  vga_clk,
    input  logic                  reset_n,
    vga_timing_gen_if.master      bus
);

    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Boundary positions as 10-bit compare constants. A sync end equal to
    // 1024 truncates to 0, where the wrap to VISIBLE takes priority anyway.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_SYNC_START);
    localparam logic [9:0] H_SYNC_FIN = 10'(H_SYNC_END);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_SYNC_START);
    localparam logic [9:0] V_SYNC_FIN = 10'(V_SYNC_END);

    // Counters are 10 bits wide; larger rasters cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } region_e;

    // Region walk for one axis, stepped only at boundary positions. Later
    // boundaries are tested first so a zero-width porch collapses cleanly.
    function automatic region_e next_region(
        input region_e    cur,
        input logic [9:0] pos,
        input logic [9:0] vis_end,
        input logic [9:0] sync_beg,
        input logic [9:0] sync_fin
    );
        region_e nxt;
        nxt = cur;
        if (pos == 10'd0)          nxt = VISIBLE;
        else if (pos == sync_fin)  nxt = BACK;
        else if (pos == sync_beg)  nxt = SYNC;
        else if (pos == vis_end)   nxt = FRONT;
        return nxt;
    endfunction

    region_e           h_state_q, h_state_d;
    region_e           v_state_q, v_state_d;
    logic [9:0]        draw_x_q, draw_x_d;
    logic [9:0]        draw_y_q, draw_y_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;
    logic              blank_q, blank_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;
    logic              line_wrap;

    // Next count, region states and decoded outputs; enable=0 holds everything.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // this block leaves one unassigned, which would infer a latch.
        draw_x_d      = draw_x_q;
        draw_y_d      = draw_y_q;
        frame_count_d = frame_count_q;
        h_state_d     = h_state_q;
        v_state_d     = v_state_q;
        blank_d       = blank_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        line_wrap     = 1'b0;

        if (bus.enable) begin
            if (draw_x_q == H_LAST) begin
                draw_x_d  = 10'd0;
                line_wrap = 1'b1;
                if (draw_y_q == V_LAST) begin
                    draw_y_d      = 10'd0;
                    frame_count_d = frame_count_q + FCNT_W'(1);
                end else begin
                    draw_y_d = draw_y_q + 10'd1;
                end
            end else begin
                draw_x_d = draw_x_q + 10'd1;
            end

            h_state_d = next_region(h_state_q, draw_x_d, H_VIS_END, H_SYNC_BEG, H_SYNC_FIN);
            // The vertical walk only moves on a line wrap, so vs switches at DrawX=0.
            if (line_wrap) begin
                v_state_d = next_region(v_state_q, draw_y_d, V_VIS_END, V_SYNC_BEG, V_SYNC_FIN);
            end

            blank_d       = (h_state_d == VISIBLE) && (v_state_d == VISIBLE);
            hs_d          = (h_state_d != SYNC);
            vs_d          = (v_state_d != SYNC);
            line_start_d  = (draw_x_d == 10'd0);
            frame_start_d = (draw_x_d == 10'd0) && (draw_y_d == 10'd0);
        end
    end

    // State and output registers; reset lands on the (0,0) outputs.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (!reset_n) begin
            h_state_q     <= VISIBLE;
            v_state_q     <= VISIBLE;
            draw_x_q      <= 10'd0;
            draw_y_q      <= 10'd0;
            frame_count_q <= '0;
            blank_q       <= 1'b1;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            frame_count_q <= frame_count_d;
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.DrawX       = draw_x_q;
    assign bus.DrawY       = draw_y_q;
    assign bus.blank       = blank_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640x480 instance (A) and a tiny 4/1/1/1 x
// 3/1/1/1 instance with a 2-bit frame counter (B), both checked every cycle
// against a region-compare reference model through expected-value queues.
module tb_vga_timing_gen;

    localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_FW = 16;
    localparam int B_HV = 4,   B_HF = 1,  B_HS = 1,  B_HB = 1;
    localparam int B_VV = 3,   B_VF = 1,  B_VS = 1,  B_VB = 1,  B_FW = 2;
    localparam int A_HT = A_HV + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VV + A_VF + A_VS + A_VB;
    localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VV + B_VF + B_VS + B_VB;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.FCNT_W(A_FW)) if_a ();
    vga_timing_gen_if #(.FCNT_W(B_FW)) if_b ();

    vga_timing_gen #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB), .FCNT_W(A_FW)
    ) dut_a (
        .vga_clk(clk), .reset_n(reset_n), .bus(if_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .FCNT_W(B_FW)
    ) dut_b (
        .vga_clk(clk), .reset_n(reset_n), .bus(if_b)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        blank;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    localparam obs_t RESET_OBS = '{x: 10'd0, y: 10'd0, blank: 1'b1, hs: 1'b1, vs: 1'b1,
                                   ls: 1'b1, fs: 1'b1, fc: 16'd0};

    obs_t q_a[$];
    obs_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   ax = 0, ay = 0, afc = 0;
    int   bx = 0, by = 0, bfc = 0;

    // Reference: outputs derived directly from the position by range compares.
    function automatic obs_t model(input int x, input int y, input int fc,
                                   input int hv, input int hf, input int hsw,
                                   input int vv, input int vf, input int vsw, input int fw);
        obs_t o;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.blank = (x < hv) && (y < vv);
        o.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
        o.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
        o.ls    = (x == 0);
        o.fs    = (x == 0) && (y == 0);
        o.fc    = 16'(fc % (1 << fw));
        return o;
    endfunction

    function automatic obs_t sample_a();
        obs_t o;
        o = '{x: if_a.DrawX, y: if_a.DrawY, blank: if_a.blank, hs: if_a.hs, vs: if_a.vs,
              ls: if_a.line_start, fs: if_a.frame_start, fc: if_a.frame_count};
        return o;
    endfunction

    function automatic obs_t sample_b();
        obs_t o;
        o = '{x: if_b.DrawX, y: if_b.DrawY, blank: if_b.blank, hs: if_b.hs, vs: if_b.vs,
              ls: if_b.line_start, fs: if_b.frame_start, fc: {14'd0, if_b.frame_count}};
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                         o.x, o.y, o.blank, o.hs, o.vs, o.ls, o.fs, o.fc);
    endfunction

    task automatic advance(inout int x, inout int y, inout int fc, input int ht, input int vt);
        x++;
        if (x == ht) begin
            x = 0;
            y++;
            if (y == vt) begin
                y = 0;
                fc++;
            end
        end
    endtask

    // Drive one clock: step the models by the enables about to be sampled,
    // queue the expected outputs, and return 2 time units after the edge.
    task automatic tick();
        if (reset_n && if_a.enable) advance(ax, ay, afc, A_HT, A_VT);
        if (reset_n && if_b.enable) advance(bx, by, bfc, B_HT, B_VT);
        q_a.push_back(model(ax, ay, afc, A_HV, A_HF, A_HS, A_VV, A_VF, A_VS, A_FW));
        q_b.push_back(model(bx, by, bfc, B_HV, B_HF, B_HS, B_VV, B_VF, B_VS, B_FW));
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: one queued expectation per edge, compared 1 unit after it.
    always @(posedge clk) begin
        obs_t exp_o, got_o;
        #1;
        if (q_a.size() > 0) begin
            exp_o = q_a.pop_front();
            got_o = sample_a();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                if (errors <= 20) $display("FAIL sb_a got %s expected %s", fmt(got_o), fmt(exp_o));
            end
        end
        if (q_b.size() > 0) begin
            exp_o = q_b.pop_front();
            got_o = sample_b();
            checks++;
            if (got_o !== exp_o) begin
                errors++;
                if (errors <= 20) $display("FAIL sb_b got %s expected %s", fmt(got_o), fmt(exp_o));
            end
        end
    end

    task automatic do_reset();
        reset_n     = 1'b0;
        if_a.enable = 1'b0;
        if_b.enable = 1'b0;
        ax = 0; ay = 0; afc = 0;
        bx = 0; by = 0; bfc = 0;
        #10;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got_o;
        do_reset();
        got_o = sample_a();
        checks++;
        if (got_o !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_a got %s expected %s", fmt(got_o), fmt(RESET_OBS));
        end
        got_o = sample_b();
        checks++;
        if (got_o !== RESET_OBS) begin
            errors++;
            $display("FAIL reset_b got %s expected %s", fmt(got_o), fmt(RESET_OBS));
        end
    endtask

    // First line wraps into line 1; the second line measures hs and blank.
    task automatic test_line();
        int hs_low = 0, first_low = -1, rise_x = -1, blank_low = 0;
        logic prev_hs;
        do_reset();
        if_a.enable = 1'b1;
        repeat (A_HT) tick();
        checks++;
        if (if_a.DrawX !== 10'd0 || if_a.DrawY !== 10'd1 || if_a.line_start !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap got x=%0d y=%0d ls=%0b expected x=0 y=1 ls=1",
                     if_a.DrawX, if_a.DrawY, if_a.line_start);
        end
        prev_hs = if_a.hs;
        for (int i = 0; i < A_HT; i++) begin
            tick();
            if (!if_a.hs) hs_low++;
            if (!if_a.hs && prev_hs && first_low < 0) first_low = int'(if_a.DrawX);
            if (if_a.hs && !prev_hs && rise_x < 0) rise_x = int'(if_a.DrawX);
            if (!if_a.blank) blank_low++;
            prev_hs = if_a.hs;
        end
        checks++;
        if (hs_low != 96) begin
            errors++;
            $display("FAIL hs_width got %0d expected 96", hs_low);
        end
        checks++;
        if (first_low != 656) begin
            errors++;
            $display("FAIL hs_fall_x got %0d expected 656", first_low);
        end
        checks++;
        if (rise_x != 752) begin
            errors++;
            $display("FAIL hs_rise_x got %0d expected 752", rise_x);
        end
        checks++;
        if (blank_low != 160) begin
            errors++;
            $display("FAIL blank_low_count got %0d expected 160", blank_low);
        end
    endtask

    task automatic test_hold();
        int changed = 0;
        do_reset();
        if_a.enable = 1'b1;
        repeat (655) tick();
        checks++;
        if (if_a.DrawX !== 10'd655 || if_a.hs !== 1'b1 || if_a.blank !== 1'b0) begin
            errors++;
            $display("FAIL hold_pre got x=%0d hs=%0b blank=%0b expected x=655 hs=1 blank=0",
                     if_a.DrawX, if_a.hs, if_a.blank);
        end
        if_a.enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if_a.DrawX !== 10'd655 || if_a.hs !== 1'b1 || if_a.blank !== 1'b0) changed++;
        end
        checks++;
        if (changed != 0) begin
            errors++;
            $display("FAIL hold_frozen got %0d changed cycles expected 0", changed);
        end
        if_a.enable = 1'b1;
        tick();
        checks++;
        if (if_a.DrawX !== 10'd656 || if_a.hs !== 1'b0) begin
            errors++;
            $display("FAIL hold_resume got x=%0d hs=%0b expected x=656 hs=0", if_a.DrawX, if_a.hs);
        end
    endtask

    // Async reset while B sits in hs/vs low and A sits in hs low.
    task automatic test_async_reset();
        obs_t got_a, got_b;
        do_reset();
        if_a.enable = 1'b1;
        if_b.enable = 1'b1;
        repeat (4 * B_HT + 5) tick();
        checks++;
        if (if_b.hs !== 1'b0 || if_b.vs !== 1'b0 || if_a.hs !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_b got hs=%0b vs=%0b a_hs=%0b expected 0 0 1",
                     if_b.hs, if_b.vs, if_a.hs);
        end
        repeat (700 - (4 * B_HT + 5)) tick();
        checks++;
        if (if_a.DrawX !== 10'd700 || if_a.hs !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_a got x=%0d hs=%0b expected x=700 hs=0", if_a.DrawX, if_a.hs);
        end
        #1 reset_n = 1'b0;
        #1;
        got_a = sample_a();
        got_b = sample_b();
        checks++;
        if (got_a !== RESET_OBS) begin
            errors++;
            $display("FAIL async_reset_a got %s expected %s", fmt(got_a), fmt(RESET_OBS));
        end
        checks++;
        if (got_b !== RESET_OBS) begin
            errors++;
            $display("FAIL async_reset_b got %s expected %s", fmt(got_b), fmt(RESET_OBS));
        end
        ax = 0; ay = 0; afc = 0;
        bx = 0; by = 0; bfc = 0;
        #10 reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (if_a.DrawX !== 10'd3 || if_a.DrawY !== 10'd0) begin
            errors++;
            $display("FAIL restart_a got x=%0d y=%0d expected x=3 y=0", if_a.DrawX, if_a.DrawY);
        end
    endtask

    // Five frames of B: frame_count wraps 1,2,3,0,1; vs low for one line each frame.
    task automatic test_frames();
        int seq[$];
        int exp_seq[5] = '{1, 2, 3, 0, 1};
        int vs_low = 0;
        do_reset();
        if_b.enable = 1'b1;
        for (int i = 0; i < 5 * B_HT * B_VT; i++) begin
            tick();
            if (if_b.frame_start) seq.push_back(int'(if_b.frame_count));
            if (i < B_HT * B_VT && !if_b.vs) vs_low++;
        end
        checks++;
        if (seq.size() != 5) begin
            errors++;
            $display("FAIL frame_strobes got %0d expected 5", seq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (seq[k] != exp_seq[k]) begin
                    errors++;
                    $display("FAIL frame_count[%0d] got %0d expected %0d", k, seq[k], exp_seq[k]);
                end
            end
        end
        checks++;
        if (vs_low != B_HT) begin
            errors++;
            $display("FAIL vs_width got %0d expected %0d", vs_low, B_HT);
        end
    endtask

    // Both instances with randomly toggling enables; the scoreboard checks each edge.
    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if_a.enable = 1'($urandom_range(0, 3) != 0);
            if_b.enable = 1'($urandom_range(0, 3) != 0);
            tick();
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        if_a.enable = 1'b0;
        if_b.enable = 1'b0;
        @(posedge clk);
        #2;
        test_reset();
        test_line();
        test_hold();
        test_async_reset();
        test_frames();
        test_back_to_back();
        if_a.enable = 1'b0;
        if_b.enable = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
